chaos_capture: RTL and testbench
================================

CHAOS_CAPTURE -- requirements
Module: chaos_capture

Interface
REQ-001 Parameter GOLDEN, default 32'h0000_0000: expected truth table of F; bit i is the F value for X=i.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle pulse that begins a new capture and clears all results.
REQ-005 in_valid  input  1  the x/f pair is valid this cycle.
REQ-006 in_ready  output  1  the block accepts the pair this cycle; a beat occurs when in_valid and in_ready are both 1.
REQ-007 x  input  5  input vector {X4,X3,X2,X1,X0} applied to the chaos function.
REQ-008 f  input  1  chaos function output for x.
REQ-009 table_o  output  32  captured truth table; bit x holds the last f accepted for x.
REQ-010 seen_o  output  32  bit x is 1 once any beat with that x has been accepted.
REQ-011 ones_o  output  6  number of 1 bits in table_o, range 0..32.
REQ-012 beats_o  output  6  number of accepted beats, saturating at 63.
REQ-013 done  output  1  all 32 minterms have been captured.
REQ-014 mismatch  output  1  table_o differs from GOLDEN; valid only while done=1.
REQ-015 dup_err  output  1  sticky flag: some x was accepted more than once.

Function
REQ-016 The FSM SHALL have three states: IDLE, CAPTURE and DONE.
REQ-017 IDLE SHALL move to CAPTURE on start; outputs are held until then.
REQ-018 On a start in any state, the next cycle SHALL have table_o, seen_o, ones_o, beats_o, dup_err, mismatch and done all 0, with the state set to CAPTURE.
REQ-019 in_ready SHALL be a registered output that is 1 only in CAPTURE; it SHALL have no combinational path from in_valid or start.
REQ-020 On a beat: table_o[x] is set to f; seen_o[x] is set to 1; beats_o increments, saturating at 63; all updates visible the next cycle.
REQ-021 ones_o SHALL be updated incrementally with the beat, without recomputing a popcount:
- +1 when old table_o[x]=0 and f=1;
- -1 when old table_o[x]=1 and f=0;
- otherwise unchanged.
REQ-022 A beat whose seen_o[x] is already 1 SHALL set dup_err, which stays set until the next start or reset; the last write wins.
REQ-023 When a beat completes seen_o to all ones, the state SHALL be DONE and done=1 on the next cycle. mismatch SHALL be set on that same edge from the post-beat table compared with GOLDEN.
REQ-024 In DONE: in_ready=0; all results are frozen; a start returns the block to CAPTURE.
REQ-025 If start and a beat occur in the same cycle while in CAPTURE, the beat SHALL be discarded (start has priority); the handshake still counts as completed from the source's view.
REQ-026 Beat order is arbitrary; in_valid gaps of any length SHALL have no effect.
REQ-027 Latency from a beat to the visible result is 1 cycle; the block accepts one beat per cycle.

Reset
REQ-028 While rst_n=0, the state SHALL be IDLE and every output 0, immediately and independent of clk.
REQ-029 Reset during CAPTURE SHALL discard the partial capture; after rst_n=1 the block waits in IDLE for start.

Structure
REQ-030 A shared package chaos_pkg SHALL hold:
- the X_W=5 and N_MINTERM=32 constants;
- the state enum {IDLE, CAPTURE, DONE}.
REQ-031 A single sub-module, chaos_onehot_dec (5-to-32 one-hot decoder), SHALL drive the table_o/seen_o write enables; all other logic stays in chaos_capture.

Verification
REQ-032 GOLDEN=32'hA5A5_0F0F; start; ascending x=0..31 with f=GOLDEN[x] back-to-back -> done=1 one cycle after beat 32; table_o=32'hA5A5_0F0F; ones_o=16; beats_o=32; mismatch=0; dup_err=0.
REQ-033 Same sweep descending, with in_valid dropped for 3 cycles every 4th beat -> identical final results; in_ready stays 1 until done.
REQ-034 Sweep with f at x=7 inverted (f=1) -> done=1; mismatch=1; table_o=32'hA5A5_0F8F; ones_o=17.
REQ-035 Beats x=3,f=1 then x=3,f=0, then the remaining 31 minterms -> dup_err=1; table_o[3]=0; beats_o=33; done=1.
REQ-036 Assert rst_n=0 after 10 beats, release, then start and run a full sweep -> all outputs 0 during reset, then a correct complete capture.
REQ-037 Pulse start in DONE, and separately pulse start together with a beat in CAPTURE -> results cleared the next cycle; the coincident beat is not recorded (beats_o=0, seen_o=0).

Source files
------------

// File: rtl/chaos_pkg.sv
// Shared constants and state encoding for the chaos-function truth-table capture.
package chaos_pkg;
  localparam int X_W       = 5;
  localparam int N_MINTERM = 32;
  localparam int CNT_W     = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_e;
endpackage

// File: rtl/chaos_onehot_dec.sv
// 5-to-32 one-hot decoder; produces the per-minterm write enable for a beat.
module chaos_onehot_dec
  import chaos_pkg::*;
(
  input  logic [X_W-1:0]       x_i,
  input  logic                 en_i,
  output logic [N_MINTERM-1:0] onehot_o
);

  // Single hot bit at position x_i when enabled, all zero otherwise.
  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[x_i] = 1'b1;
  end

endmodule

// File: rtl/chaos_capture.sv
// Captures the truth table of a 5-input chaos function one x/f beat at a time,
// tracks coverage, duplicates and a running ones count, and compares the
// completed table against GOLDEN.
module chaos_capture
  import chaos_pkg::*;
#(
  parameter logic [N_MINTERM-1:0] GOLDEN = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [X_W-1:0]       x,
  input  logic                 f,
  output logic [N_MINTERM-1:0] table_o,
  output logic [N_MINTERM-1:0] seen_o,
  output logic [CNT_W-1:0]     ones_o,
  output logic [CNT_W-1:0]     beats_o,
  output logic                 done,
  output logic                 mismatch,
  output logic                 dup_err
);

  state_e               state_q, state_d;
  logic [N_MINTERM-1:0] table_q, table_d;
  logic [N_MINTERM-1:0] seen_q, seen_d;
  logic [CNT_W-1:0]     ones_q, ones_d;
  logic [CNT_W-1:0]     beats_q, beats_d;
  logic                 mis_q, mis_d;
  logic                 dup_q, dup_d;
  logic                 rdy_q, rdy_d;
  logic                 beat;
  logic [N_MINTERM-1:0] we;

  // A start in the same cycle wins over the beat, so the beat is dropped here.
  assign beat = in_valid & rdy_q & ~start;

  chaos_onehot_dec u_dec (
    .x_i      (x),
    .en_i     (beat),
    .onehot_o (we)
  );

  // Next-state and result update; start clears everything from any state.
  always_comb begin
    state_d = state_q;
    table_d = table_q;
    seen_d  = seen_q;
    ones_d  = ones_q;
    beats_d = beats_q;
    mis_d   = mis_q;
    dup_d   = dup_q;
    if (start) begin
      state_d = CAPTURE;
      table_d = '0;
      seen_d  = '0;
      ones_d  = '0;
      beats_d = '0;
      mis_d   = 1'b0;
      dup_d   = 1'b0;
    end else begin
      case (state_q)
        CAPTURE: begin
          if (beat) begin
            table_d = (table_q & ~we) | (we & {N_MINTERM{f}});
            seen_d  = seen_q | we;
            if (beats_q != {CNT_W{1'b1}}) beats_d = beats_q + 1'b1;
            // Incremental popcount: only the written bit can change.
            if (!table_q[x] && f)      ones_d = ones_q + 1'b1;
            else if (table_q[x] && !f) ones_d = ones_q - 1'b1;
            if (|(seen_q & we)) dup_d = 1'b1;
            if (&seen_d) begin
              state_d = DONE;
              mis_d   = (table_d != GOLDEN);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Ready is a flop copy of "next state is CAPTURE", so it never depends
  // combinationally on in_valid or start at the output.
  assign rdy_d = (state_d == CAPTURE);

  // State and result registers, all cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      table_q <= '0;
      seen_q  <= '0;
      ones_q  <= '0;
      beats_q <= '0;
      mis_q   <= 1'b0;
      dup_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      table_q <= table_d;
      seen_q  <= seen_d;
      ones_q  <= ones_d;
      beats_q <= beats_d;
      mis_q   <= mis_d;
      dup_q   <= dup_d;
      rdy_q   <= rdy_d;
    end
  end

  assign in_ready = rdy_q;
  assign table_o  = table_q;
  assign seen_o   = seen_q;
  assign ones_o   = ones_q;
  assign beats_o  = beats_q;
  assign done     = (state_q == DONE);
  assign mismatch = mis_q;
  assign dup_err  = dup_q;

endmodule

// File: tb/tb_chaos_capture.sv
// Scoreboard bench for chaos_capture: each cycle's expected result is pushed
// when stimulus is driven and popped/compared after the clock edge.
module tb_chaos_capture;
  import chaos_pkg::*;

  localparam logic [31:0] G = 32'hA5A5_0F0F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  x = '0;
  logic        f = 1'b0;
  logic [31:0] table_o, seen_o;
  logic [5:0]  ones_o, beats_o;
  logic        done, mismatch, dup_err;

  chaos_capture #(.GOLDEN(G)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .x(x), .f(f), .table_o(table_o), .seen_o(seen_o),
    .ones_o(ones_o), .beats_o(beats_o), .done(done), .mismatch(mismatch),
    .dup_err(dup_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] tbl;
    logic [31:0] seen;
    logic [5:0]  ones;
    logic [5:0]  beats;
    logic        done;
    logic        mis;
    logic        dup;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] g_v = G;

  // Reference model state
  logic [31:0] m_tbl, m_seen;
  logic [5:0]  m_beats;
  logic        m_done, m_mis, m_dup, m_rdy;

  function automatic exp_t obs();
    return {table_o, seen_o, ones_o, beats_o, done, mismatch, dup_err};
  endfunction

  function automatic exp_t mexp();
    return {m_tbl, m_seen, 6'($countones(m_tbl)), m_beats, m_done, m_mis, m_dup};
  endfunction

  task automatic model_clear();
    m_tbl = '0; m_seen = '0; m_beats = '0;
    m_done = 1'b0; m_mis = 1'b0; m_dup = 1'b0;
  endtask

  // One clock cycle of stimulus with scoreboard push / pop-compare.
  task automatic step(input logic v, input logic [4:0] xx, input logic ff, input logic st);
    exp_t e, o;
    in_valid = v; x = xx; f = ff; start = st;
    total++;
    if (in_ready !== m_rdy) begin
      bad++;
      $display("FAIL in_ready x=%0d st=%b: got %b want %b", xx, st, in_ready, m_rdy);
    end
    if (st) begin
      model_clear();
      m_rdy = 1'b1;
    end else if (v && m_rdy) begin
      if (m_seen[xx]) m_dup = 1'b1;
      m_tbl[xx]  = ff;
      m_seen[xx] = 1'b1;
      if (m_beats != 6'd63) m_beats = m_beats + 6'd1;
      if (&m_seen) begin
        m_done = 1'b1;
        m_rdy  = 1'b0;
        m_mis  = (m_tbl != G);
      end
    end
    sb.push_back(mexp());
    @(posedge clk); #1;
    in_valid = 1'b0; start = 1'b0;
    e = sb.pop_front();
    o = obs();
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL step v=%b x=%0d f=%b st=%b: got %h want %h", v, xx, ff, st, o, e);
    end
  endtask

  task automatic check_zero(input string tag);
    total++;
    if (obs() !== '0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s: got %h rdy=%b want all zero", tag, obs(), in_ready);
    end
  endtask

  task automatic check_final(input string tag, input logic [31:0] tb, input logic [5:0] on,
                             input logic [5:0] bt, input logic mi, input logic du);
    total++;
    if (table_o !== tb || ones_o !== on || beats_o !== bt || done !== 1'b1 ||
        mismatch !== mi || dup_err !== du) begin
      bad++;
      $display("FAIL %s: got tbl=%h ones=%0d beats=%0d done=%b mis=%b dup=%b want tbl=%h ones=%0d beats=%0d done=1 mis=%b dup=%b",
               tag, table_o, ones_o, beats_o, done, mismatch, dup_err, tb, on, bt, mi, du);
    end
  endtask

  task automatic test_reset();
    #3;
    check_zero("reset_initial");
    model_clear();
    m_rdy = 1'b0;
    #9 rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 5'd4, 1'b1, 1'b0);  // ignored while IDLE
    step(1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic test_ascending();
    step(1'b0, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < 32; i++) step(1'b1, 5'(i), g_v[i], 1'b0);
    check_final("ascending", 32'hA5A5_0F0F, 6'd16, 6'd32, 1'b0, 1'b0);
    step(1'b1, 5'd2, 1'b0, 1'b0);  // frozen in DONE
  endtask

  task automatic test_descending_gaps();
    step(1'b0, 5'd0, 1'b0, 1'b1);
    for (int i = 31; i >= 0; i--) begin
      step(1'b1, 5'(i), g_v[i], 1'b0);
      if ((31 - i) % 4 == 3 && i != 0)
        for (int k = 0; k < 3; k++) step(1'b0, 5'd0, 1'b0, 1'b0);
    end
    check_final("descending_gaps", 32'hA5A5_0F0F, 6'd16, 6'd32, 1'b0, 1'b0);
  endtask

  task automatic test_flip7();
    step(1'b0, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < 32; i++) step(1'b1, 5'(i), (i == 7) ? 1'b1 : g_v[i], 1'b0);
    check_final("flip7", 32'hA5A5_0F8F, 6'd17, 6'd32, 1'b1, 1'b0);
  endtask

  task automatic test_dup();
    step(1'b0, 5'd0, 1'b0, 1'b1);
    step(1'b1, 5'd3, 1'b1, 1'b0);
    step(1'b1, 5'd3, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) if (i != 3) step(1'b1, 5'(i), g_v[i], 1'b0);
    check_final("dup", 32'hA5A5_0F07, 6'd15, 6'd33, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid();
    step(1'b0, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 5'(i), g_v[i], 1'b0);
    #2 rst_n = 1'b0;
    #1 check_zero("reset_async");
    model_clear();
    m_rdy = 1'b0;
    @(posedge clk); #1;
    check_zero("reset_held");
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 5'd1, 1'b1, 1'b0);  // IDLE waits for start
    step(1'b0, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < 32; i++) step(1'b1, 5'(i), g_v[i], 1'b0);
    check_final("after_reset", 32'hA5A5_0F0F, 6'd16, 6'd32, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back_start();
    step(1'b0, 5'd0, 1'b0, 1'b1);  // start from DONE
    for (int i = 0; i < 5; i++) step(1'b1, 5'(i + 8), 1'b1, 1'b0);
    step(1'b1, 5'd9, 1'b1, 1'b1);  // coincident start + beat
    total++;
    if (beats_o !== 6'd0 || seen_o !== 32'd0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL start_with_beat: got beats=%0d seen=%h rdy=%b want 0 0 1",
               beats_o, seen_o, in_ready);
    end
  endtask

  initial begin
    model_clear();
    m_rdy = 1'b0;
    test_reset();
    test_ascending();
    test_descending_gaps();
    test_flip7();
    test_dup();
    test_reset_mid();
    test_back_to_back_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
